// File: rtl/color_matrix_gen_if.sv
// AXI4-Stream bundle shared by the colour pipe stages.
// Ports: tvalid/tready handshake, tdata/tkeep/tstrb payload, tlast/tuser framing, tid/tdest routing.
// The master drives everything except tready; the slave drives tready only.
interface axi4_stream_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [DATA_W/8-1:0] tstrb;
  logic                tlast;
  logic                tuser;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/color_matrix_gen.sv
// Affine colour matrix: out_k = sum_j(a_kj * in_j) + a_k,CH_NUM on every pixel, 4-cycle latency.
// Ports: coefficient shadow write/apply (swap on the next accepted SOF beat), bypass, AXI4-Stream in/out.
// Backpressure: one global stall enable, the whole pipe freezes when the output beat is not taken.
module color_matrix_gen #(
  parameter int  PX_WIDTH    = 10,
  parameter int  CH_NUM      = 3,
  parameter int  INT_WIDTH   = 10,
  parameter int  FRACT_WIDTH = 10,
  parameter int  ROUND_EN    = 1,
  parameter int  ID_WIDTH    = 4,
  parameter int  DEST_WIDTH  = 4,
  localparam int COEF_WIDTH  = 1 + INT_WIDTH + FRACT_WIDTH,
  localparam int NCOEF       = CH_NUM * (CH_NUM + 1),
  localparam int ADDR_WIDTH  = $clog2(NCOEF),
  localparam int TDATA_WIDTH = ((CH_NUM * PX_WIDTH + 7) / 8) * 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         coef_wr_i,
  input  logic [ADDR_WIDTH-1:0]        coef_addr_i,
  input  logic signed [COEF_WIDTH-1:0] coef_data_i,
  input  logic                         coef_apply_i,
  input  logic                         bypass_i,
  output logic                         coef_pending_o,
  output logic                         coef_applied_o,
  axi4_stream_if.slave                 video_i,
  axi4_stream_if.master                video_o
);

  localparam int PROD_W = PX_WIDTH + COEF_WIDTH + 1;
  localparam int ACC_W  = PROD_W + $clog2(CH_NUM + 1);
  localparam int NPAIR  = (CH_NUM + 2) / 2;
  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int SB_W   = 2 + 2 * KEEP_W + ID_WIDTH + DEST_WIDTH;

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << FRACT_WIDTH);
  localparam logic signed [ACC_W-1:0]      RND_C    = (ROUND_EN != 0) ? ACC_W'(1 << (FRACT_WIDTH - 1)) : '0;
  localparam logic signed [ACC_W-1:0]      PXMAX_A  = ACC_W'((1 << PX_WIDTH) - 1);

  function automatic logic [TDATA_WIDTH-1:0] f_data_mask();
    logic [TDATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < CH_NUM * PX_WIDTH; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic signed [COEF_WIDTH-1:0] f_ident(input int idx);
    return ((idx / (CH_NUM + 1)) == (idx % (CH_NUM + 1))) ? COEF_ONE : '0;
  endfunction

  localparam logic [TDATA_WIDTH-1:0] DATA_MASK = f_data_mask();

  // Coefficient banks and frame-swap control
  logic signed [COEF_WIDTH-1:0] r_shadow [NCOEF];
  logic signed [COEF_WIDTH-1:0] r_active [NCOEF];
  logic                         r_bypass;
  logic                         r_pending;
  logic                         r_applied;

  // Pipeline registers
  logic                         r_s1_vld, r_s2_vld, r_s3_vld, r_s4_vld;
  logic signed [PROD_W-1:0]     r_s1_prod [CH_NUM][CH_NUM];
  logic signed [COEF_WIDTH-1:0] r_s1_off  [CH_NUM];
  logic signed [ACC_W-1:0]      r_s2_part [CH_NUM][NPAIR];
  logic signed [ACC_W-1:0]      r_s3_sum  [CH_NUM];
  logic                         r_s1_byp, r_s2_byp, r_s3_byp;
  logic [TDATA_WIDTH-1:0]       r_s1_data, r_s2_data, r_s3_data, r_s4_data;
  logic [SB_W-1:0]              r_s1_sb, r_s2_sb, r_s3_sb, r_s4_sb;

  logic                         w_en;
  logic                         w_swap;
  logic                         w_byp;
  logic [SB_W-1:0]              w_sb_in;
  logic signed [COEF_WIDTH-1:0] w_bank [NCOEF];
  logic signed [PROD_W-1:0]     w_pxe  [CH_NUM];
  logic signed [PROD_W-1:0]     w_prod [CH_NUM][CH_NUM];
  logic signed [COEF_WIDTH-1:0] w_off  [CH_NUM];
  logic signed [ACC_W-1:0]      w_term [CH_NUM][2*NPAIR];
  logic signed [ACC_W-1:0]      w_part [CH_NUM][NPAIR];
  logic signed [ACC_W-1:0]      w_sum  [CH_NUM];
  logic signed [ACC_W-1:0]      w_rnd  [CH_NUM];
  logic signed [ACC_W-1:0]      w_int  [CH_NUM];
  logic [PX_WIDTH-1:0]          w_pix  [CH_NUM];
  logic [TDATA_WIDTH-1:0]       w_out;

  assign w_en          = !r_s4_vld | video_o.tready;
  assign video_i.tready = w_en;
  // Swap on the first accepted start-of-frame beat while a copy is armed
  assign w_swap        = r_pending & video_i.tvalid & w_en & video_i.tuser;
  assign w_sb_in       = {video_i.tlast, video_i.tuser, video_i.tkeep, video_i.tstrb,
                          video_i.tid, video_i.tdest};

  assign coef_pending_o = r_pending;
  assign coef_applied_o = r_applied;
  assign video_o.tvalid = r_s4_vld;
  assign video_o.tdata  = r_s4_data;
  assign {video_o.tlast, video_o.tuser, video_o.tkeep, video_o.tstrb,
          video_o.tid, video_o.tdest} = r_s4_sb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCOEF; i++) begin
        r_shadow[i] <= f_ident(i);
        r_active[i] <= f_ident(i);
      end
      r_bypass  <= 1'b0;
      r_pending <= 1'b0;
      r_applied <= 1'b0;
    end else begin
      if (coef_wr_i && (32'(coef_addr_i) < NCOEF)) r_shadow[coef_addr_i] <= coef_data_i;
      // Copy reads the pre-write shadow since both updates land on the same edge
      if (w_swap) begin
        for (int i = 0; i < NCOEF; i++) r_active[i] <= r_shadow[i];
        r_bypass <= bypass_i;
      end
      r_applied <= w_swap;
      if (w_swap)            r_pending <= coef_apply_i;
      else if (coef_apply_i) r_pending <= 1'b1;
    end
  end

  // The swapping beat already sees the new bank, so select before registering
  always_comb begin
    for (int i = 0; i < NCOEF; i++) w_bank[i] = w_swap ? r_shadow[i] : r_active[i];
    w_byp = w_swap ? bypass_i : r_bypass;
  end

  // S1: zero-extended pixel times signed coefficient; offsets ride along to S2
  always_comb begin
    for (int j = 0; j < CH_NUM; j++)
      w_pxe[j] = signed'(PROD_W'(video_i.tdata[j*PX_WIDTH +: PX_WIDTH]));
    for (int k = 0; k < CH_NUM; k++) begin
      for (int j = 0; j < CH_NUM; j++)
        w_prod[k][j] = w_pxe[j] * PROD_W'(w_bank[k*(CH_NUM+1) + j]);
      w_off[k] = w_bank[k*(CH_NUM+1) + CH_NUM];
    end
  end

  // S2: pairwise sums; offset already sits at FRACT_WIDTH fractional bits like the products
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      for (int i = 0; i < 2*NPAIR; i++) w_term[k][i] = '0;
      for (int i = 0; i < CH_NUM; i++) w_term[k][i] = ACC_W'(r_s1_prod[k][i]);
      w_term[k][CH_NUM] = ACC_W'(r_s1_off[k]);
      for (int p = 0; p < NPAIR; p++) w_part[k][p] = w_term[k][2*p] + w_term[k][2*p+1];
    end
  end

  // S3: final sum
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      w_sum[k] = '0;
      for (int p = 0; p < NPAIR; p++) w_sum[k] = w_sum[k] + r_s2_part[k][p];
    end
  end

  // S4: round half-up, drop fraction, clip to [0, 2^PX_WIDTH-1]
  always_comb begin
    w_out = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_rnd[k] = r_s3_sum[k] + RND_C;
      w_int[k] = w_rnd[k] >>> FRACT_WIDTH;
      if (w_int[k][ACC_W-1])      w_pix[k] = '0;
      else if (w_int[k] > PXMAX_A) w_pix[k] = '1;
      else                         w_pix[k] = w_int[k][PX_WIDTH-1:0];
      w_out[k*PX_WIDTH +: PX_WIDTH] = w_pix[k];
    end
    if (r_s3_byp) w_out = r_s3_data & DATA_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_s1_prod <= w_prod;
      r_s1_off  <= w_off;
      r_s1_byp  <= w_byp;
      r_s1_data <= video_i.tdata;
      r_s1_sb   <= w_sb_in;
      r_s2_part <= w_part;
      r_s2_byp  <= r_s1_byp;
      r_s2_data <= r_s1_data;
      r_s2_sb   <= r_s1_sb;
      r_s3_sum  <= w_sum;
      r_s3_byp  <= r_s2_byp;
      r_s3_data <= r_s2_data;
      r_s3_sb   <= r_s2_sb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s4_vld  <= 1'b0;
      r_s4_data <= '0;
      r_s4_sb   <= '0;
    end else if (w_en) begin
      r_s1_vld  <= video_i.tvalid;
      r_s2_vld  <= r_s1_vld;
      r_s3_vld  <= r_s2_vld;
      r_s4_vld  <= r_s3_vld;
      r_s4_data <= w_out;
      r_s4_sb   <= r_s3_sb;
    end
  end

endmodule

// File: tb/tb_color_matrix_gen.sv
module tb_color_matrix_gen;
  localparam int CW = 21;
  localparam logic [31:0] PAD = 32'hC000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 coef_wr;
  logic [3:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_apply;
  logic                 bypass;
  logic                 pending;
  logic                 applied;

  axi4_stream_if #(.DATA_W(32)) vin ();
  axi4_stream_if #(.DATA_W(32)) vout ();

  color_matrix_gen dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .coef_wr_i      (coef_wr),
    .coef_addr_i    (coef_addr),
    .coef_data_i    (coef_data),
    .coef_apply_i   (coef_apply),
    .bypass_i       (bypass),
    .coef_pending_o (pending),
    .coef_applied_o (applied),
    .video_i        (vin),
    .video_o        (vout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q_dat [$];
  logic        q_usr [$];
  logic        q_lst [$];

  // Output monitor: inputs only change on negedge, so +1 after negedge shows the next handshake
  always @(negedge clk) begin
    #1;
    if (vout.tvalid && vout.tready) begin
      q_dat.push_back(vout.tdata);
      q_usr.push_back(vout.tuser);
      q_lst.push_back(vout.tlast);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pix3(input int c0, input int c1, input int c2);
    logic [9:0] a, b, c;
    a = c0[9:0]; b = c1[9:0]; c = c2[9:0];
    return {2'b00, c, b, a};
  endfunction

  task automatic clear_q();
    q_dat.delete(); q_usr.delete(); q_lst.delete();
  endtask

  task automatic wr(input int row, input int col, input int val);
    @(negedge clk);
    coef_wr = 1'b1; coef_addr = 4'(row * 4 + col); coef_data = CW'(val);
    @(negedge clk);
    coef_wr = 1'b0;
  endtask

  task automatic load_identity();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) wr(r, c, (r == c) ? 1024 : 0);
  endtask

  task automatic do_apply();
    @(negedge clk); coef_apply = 1'b1;
    @(negedge clk); coef_apply = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic sof, input logic last);
    @(negedge clk);
    vin.tvalid = 1'b1; vin.tdata = d; vin.tuser = sof; vin.tlast = last;
    @(negedge clk);
    vin.tvalid = 1'b0; vin.tuser = 1'b0; vin.tlast = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 60 && q_dat.size() < n; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_apply = 1'b0; bypass = 1'b0;
    vin.tvalid = 1'b0; vin.tdata = '0; vin.tkeep = 4'hF; vin.tstrb = 4'hF;
    vin.tlast = 1'b0; vin.tuser = 1'b0; vin.tid = '0; vin.tdest = '0;
    vout.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (vout.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", vout.tvalid); end
    n_vec++; if (vout.tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata got %h want 0", vout.tdata); end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending); end
    n_vec++; if (applied !== 1'b0) begin n_err++; $display("FAIL reset_applied got %b want 0", applied); end
    @(negedge clk); rst = 1'b0;
    #1;
    n_vec++; if (vin.tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got %b want 1", vin.tready); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity_latency();
    logic [31:0] exp;
    exp = pix3(100, 512, 1023);
    clear_q();
    @(negedge clk);
    vin.tvalid = 1'b1; vin.tdata = exp | PAD; vin.tuser = 1'b1; vin.tlast = 1'b1;
    vin.tid = 4'd5; vin.tdest = 4'd9; vin.tkeep = 4'hF;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (e < 3) begin
        n_vec++; if (vout.tvalid !== 1'b0) begin n_err++; $display("FAIL lat_early_e%0d tvalid got %b want 0", e, vout.tvalid); end
      end else begin
        n_vec++; if (vout.tvalid !== 1'b1) begin n_err++; $display("FAIL lat_tvalid got %b want 1", vout.tvalid); end
        n_vec++; if (vout.tdata !== exp) begin n_err++; $display("FAIL ident_data got %h want %h", vout.tdata, exp); end
        n_vec++; if ({vout.tuser, vout.tlast, vout.tid, vout.tdest, vout.tkeep} !== {1'b1, 1'b1, 4'd5, 4'd9, 4'hF})
          begin n_err++; $display("FAIL ident_sideband got %b%b %h %h %h want 1 1 5 9 f", vout.tuser, vout.tlast, vout.tid, vout.tdest, vout.tkeep); end
      end
      if (e == 0) begin
        @(negedge clk);
        vin.tvalid = 1'b0; vin.tuser = 1'b0; vin.tlast = 1'b0; vin.tid = '0; vin.tdest = '0;
      end
    end
    repeat (3) @(negedge clk);
    clear_q();
  endtask

  task automatic test_matrix();
    load_identity();
    wr(0, 0, 2048); wr(0, 1, -512); wr(0, 3, -10240);
    do_apply();
    #1;
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL matrix_pending got %b want 1", pending); end
    clear_q();
    @(negedge clk);
    vin.tvalid = 1'b1; vin.tdata = pix3(300, 200, 0); vin.tuser = 1'b1; vin.tlast = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({applied, pending} !== 2'b10) begin n_err++; $display("FAIL matrix_swap applied/pending got %b%b want 10", applied, pending); end
    @(negedge clk);
    vin.tvalid = 1'b0; vin.tuser = 1'b0; vin.tlast = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (applied !== 1'b0) begin n_err++; $display("FAIL matrix_pulse_width got %b want 0", applied); end
    wait_out(1);
    n_vec++;
    if (q_dat.size() != 1) begin n_err++; $display("FAIL matrix_count got %0d want 1", q_dat.size()); end
    else if (q_dat[0] !== pix3(490, 200, 0)) begin n_err++; $display("FAIL matrix_data got %h want %h", q_dat[0], pix3(490, 200, 0)); end
    clear_q();
  endtask

  task automatic test_saturation();
    load_identity();
    wr(0, 0, 4096); wr(1, 3, -1024000);
    do_apply();
    clear_q();
    send(pix3(800, 5, 7), 1'b1, 1'b1);
    wait_out(1);
    n_vec++;
    if (q_dat.size() != 1) begin n_err++; $display("FAIL sat_count got %0d want 1", q_dat.size()); end
    else if (q_dat[0] !== pix3(1023, 0, 7)) begin n_err++; $display("FAIL sat_data got %h want %h", q_dat[0], pix3(1023, 0, 7)); end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL sat_pending got %b want 0", pending); end
    clear_q();
  endtask

  task automatic test_rounding();
    load_identity();
    wr(0, 0, 512); wr(1, 1, 512); wr(2, 2, 512);
    do_apply();
    clear_q();
    send(pix3(3, 2, 5), 1'b1, 1'b1);
    wait_out(1);
    n_vec++;
    if (q_dat.size() != 1) begin n_err++; $display("FAIL round_count got %0d want 1", q_dat.size()); end
    else if (q_dat[0] !== pix3(2, 1, 3)) begin n_err++; $display("FAIL round_data got %h want %h", q_dat[0], pix3(2, 1, 3)); end
    clear_q();
  endtask

  task automatic test_midframe_swap();
    logic [31:0] exp [5];
    exp[0] = pix3(50, 5, 10);  exp[1] = pix3(50, 5, 10);
    exp[2] = pix3(200, 5, 10); exp[3] = pix3(200, 5, 10);
    exp[4] = pix3(200, 40, 10);
    wr(0, 0, 2048);
    clear_q();
    send(pix3(100, 10, 20), 1'b0, 1'b0);
    do_apply();
    #1;
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL mid_pending_armed got %b want 1", pending); end
    send(pix3(100, 10, 20), 1'b0, 1'b1);
    #1;
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL mid_pending_hold got %b want 1", pending); end
    // SOF with a coincident shadow write and a coincident apply
    @(negedge clk);
    vin.tvalid = 1'b1; vin.tdata = pix3(100, 10, 20); vin.tuser = 1'b1;
    coef_wr = 1'b1; coef_addr = 4'd5; coef_data = CW'(4096); coef_apply = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({applied, pending} !== 2'b11) begin n_err++; $display("FAIL mid_swap_rearm applied/pending got %b%b want 11", applied, pending); end
    @(negedge clk);
    vin.tvalid = 1'b0; vin.tuser = 1'b0; coef_wr = 1'b0; coef_apply = 1'b0;
    send(pix3(100, 10, 20), 1'b0, 1'b1);
    send(pix3(100, 10, 20), 1'b1, 1'b1);
    wait_out(5);
    n_vec++; if (q_dat.size() != 5) begin n_err++; $display("FAIL mid_count got %0d want 5", q_dat.size()); end
    for (int i = 0; i < 5 && i < q_dat.size(); i++) begin
      n_vec++;
      if (q_dat[i] !== exp[i]) begin n_err++; $display("FAIL mid_beat%0d got %h want %h", i, q_dat[i], exp[i]); end
    end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL mid_pending_final got %b want 0", pending); end
    clear_q();
  endtask

  task automatic test_bypass();
    logic [31:0] exp [3];
    exp[0] = pix3(123, 456, 789); exp[1] = pix3(1, 2, 3); exp[2] = pix3(4, 5, 6);
    bypass = 1'b1;
    do_apply();
    clear_q();
    send(exp[0] | PAD, 1'b1, 1'b0);
    bypass = 1'b0;
    send(exp[1], 1'b0, 1'b0);
    send(exp[2] | PAD, 1'b0, 1'b1);
    wait_out(3);
    n_vec++; if (q_dat.size() != 3) begin n_err++; $display("FAIL byp_count got %0d want 3", q_dat.size()); end
    for (int i = 0; i < 3 && i < q_dat.size(); i++) begin
      n_vec++;
      if (q_dat[i] !== exp[i]) begin n_err++; $display("FAIL byp_beat%0d got %h want %h", i, q_dat[i], exp[i]); end
    end
    clear_q();
  endtask

  task automatic test_reset_midframe();
    logic [31:0] b [4];
    b[0] = pix3(10, 20, 30); b[1] = pix3(11, 21, 31); b[2] = pix3(12, 22, 32); b[3] = pix3(13, 23, 33);
    clear_q();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vin.tvalid = 1'b1; vin.tdata = b[i]; vin.tuser = (i == 0);
    end
    @(negedge clk);
    vin.tvalid = 1'b0; vin.tuser = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (vout.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", vout.tvalid); end
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (q_dat.size() != 1) begin n_err++; $display("FAIL rstmid_drop count got %0d want 1", q_dat.size()); end
    else if (q_dat[0] !== b[0]) begin n_err++; $display("FAIL rstmid_first got %h want %h", q_dat[0], b[0]); end
    clear_q();
    do_apply();
    send(pix3(100, 512, 1023), 1'b1, 1'b1);
    wait_out(1);
    n_vec++;
    if (q_dat.size() != 1) begin n_err++; $display("FAIL rstmid_ident count got %0d want 1", q_dat.size()); end
    else if (q_dat[0] !== pix3(100, 512, 1023)) begin n_err++; $display("FAIL rstmid_ident got %h want %h", q_dat[0], pix3(100, 512, 1023)); end
    clear_q();
  endtask

  task automatic test_random_backpressure();
    int  idx;
    int  cyc;
    bit  vld;
    logic [31:0] e;
    idx = 0; cyc = 0; vld = 1'b0;
    clear_q();
    while ((idx < 64 || q_dat.size() < 64) && cyc < 4000) begin
      @(negedge clk);
      vout.tready = ($urandom_range(0, 3) != 0);
      if (idx < 64) begin
        if (!vld) vld = ($urandom_range(0, 2) != 0);
        vin.tvalid = vld;
        vin.tdata  = pix3(idx * 7 + 1, idx * 13 + 2, 1023 - idx);
        vin.tuser  = (idx == 0);
        vin.tlast  = (idx == 63);
      end else begin
        vld = 1'b0; vin.tvalid = 1'b0; vin.tuser = 1'b0; vin.tlast = 1'b0;
      end
      #1;
      if (vld && vin.tready) begin idx++; vld = 1'b0; end
      cyc++;
    end
    @(negedge clk);
    vin.tvalid = 1'b0; vin.tuser = 1'b0; vin.tlast = 1'b0; vout.tready = 1'b1;
    repeat (8) @(negedge clk);
    n_vec++; if (q_dat.size() != 64) begin n_err++; $display("FAIL rand_count got %0d want 64", q_dat.size()); end
    for (int i = 0; i < 64 && i < q_dat.size(); i++) begin
      e = pix3(i * 7 + 1, i * 13 + 2, 1023 - i);
      n_vec++;
      if (q_dat[i] !== e || q_usr[i] !== (i == 0) || q_lst[i] !== (i == 63)) begin
        n_err++;
        $display("FAIL rand_beat%0d got %h u%b l%b want %h u%b l%b", i, q_dat[i], q_usr[i], q_lst[i], e, (i == 0), (i == 63));
      end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_identity_latency();
    test_matrix();
    test_saturation();
    test_rounding();
    test_midframe_swap();
    test_bypass();
    test_reset_midframe();
    test_random_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
